// File: rtl/ulpi_reg_arb.sv
// ulpi_reg_arb: round-robin arbiter and req/ack sequencer that lets two
// requesters share the single ULPI PHY register-access port.
module ulpi_reg_arb #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  REQ,
  input  logic [1:0]  WE,
  input  logic [11:0] ADDR,
  input  logic [15:0] WDATA,
  output logic [1:0]  DONE,
  output logic [1:0]  ERR,
  output logic [7:0]  RDATA,
  output logic        BUSY,
  output logic [5:0]  REG_ADDR,
  output logic [7:0]  REG_DATA_WRITE,
  input  logic [7:0]  REG_DATA_READ,
  output logic        REG_WRITE_REQ,
  input  logic        REG_WRITE_ACK,
  output logic        REG_READ_REQ,
  input  logic        REG_READ_ACK
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             win_q, win_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       err_q, err_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             busy_q, busy_d;
  logic [5:0]       reg_addr_q, reg_addr_d;
  logic [7:0]       reg_wdata_q, reg_wdata_d;
  logic             wr_req_q, wr_req_d;
  logic             rd_req_q, rd_req_d;
  logic             grant_c;
  logic             ack_c;

  // State, pointer and registered outputs; synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b1;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      wr_req_q    <= 1'b0;
      rd_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      wr_req_q    <= wr_req_d;
      rd_req_q    <= rd_req_d;
    end
  end

  // Next-state, arbitration, timeout and next-output logic
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    done_d      = '0;
    err_d       = '0;
    rdata_d     = '0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    grant_c     = 1'b0;
    ack_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (REQ != 2'b00) begin
          // Both requesting: the one that did not win last time goes next
          grant_c     = (REQ == 2'b11) ? ~ptr_q : REQ[1];
          ptr_d       = grant_c;
          win_d       = grant_c;
          we_d        = WE[grant_c];
          reg_addr_d  = grant_c ? ADDR[11:6] : ADDR[5:0];
          reg_wdata_d = grant_c ? WDATA[15:8] : WDATA[7:0];
          cnt_d       = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        ack_c = we_q ? REG_WRITE_ACK : REG_READ_ACK;
        if (ack_c) begin
          // An ack on the timeout cycle still counts as success
          state_d        = FINISH;
          done_d[win_q]  = 1'b1;
          rdata_d        = we_q ? 8'h00 : REG_DATA_READ;
        end else if (cnt_q == TO_LAST) begin
          state_d        = FINISH;
          done_d[win_q]  = 1'b1;
          err_d[win_q]   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    wr_req_d = (state_d == ISSUE) && we_d;
    rd_req_d = (state_d == ISSUE) && !we_d;
    busy_d   = (state_d != IDLE);
  end

  assign DONE           = done_q;
  assign ERR            = err_q;
  assign RDATA          = rdata_q;
  assign BUSY           = busy_q;
  assign REG_ADDR       = reg_addr_q;
  assign REG_DATA_WRITE = reg_wdata_q;
  assign REG_WRITE_REQ  = wr_req_q;
  assign REG_READ_REQ   = rd_req_q;

endmodule

// File: tb/tb_ulpi_reg_arb.sv
// Cycle-by-cycle vector bench for ulpi_reg_arb with a short timeout.
module tb_ulpi_reg_arb;

  localparam int unsigned TO = 8;

  logic        CLK;
  logic        RST;
  logic [1:0]  REQ;
  logic [1:0]  WE;
  logic [11:0] ADDR;
  logic [15:0] WDATA;
  logic [1:0]  DONE;
  logic [1:0]  ERR;
  logic [7:0]  RDATA;
  logic        BUSY;
  logic [5:0]  REG_ADDR;
  logic [7:0]  REG_DATA_WRITE;
  logic [7:0]  REG_DATA_READ;
  logic        REG_WRITE_REQ;
  logic        REG_WRITE_ACK;
  logic        REG_READ_REQ;
  logic        REG_READ_ACK;

  int checks = 0;
  int failures = 0;

  ulpi_reg_arb #(.TIMEOUT(TO)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .REQ            (REQ),
    .WE             (WE),
    .ADDR           (ADDR),
    .WDATA          (WDATA),
    .DONE           (DONE),
    .ERR            (ERR),
    .RDATA          (RDATA),
    .BUSY           (BUSY),
    .REG_ADDR       (REG_ADDR),
    .REG_DATA_WRITE (REG_DATA_WRITE),
    .REG_DATA_READ  (REG_DATA_READ),
    .REG_WRITE_REQ  (REG_WRITE_REQ),
    .REG_WRITE_ACK  (REG_WRITE_ACK),
    .REG_READ_REQ   (REG_READ_REQ),
    .REG_READ_ACK   (REG_READ_ACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs for one cycle plus the outputs expected during that same cycle
  typedef struct packed {
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [7:0]  rd;
    logic        wack;
    logic        rack;
    logic [28:0] exp;
  } vec_t;

  vec_t vecs[$];

  // {DONE, ERR, RDATA, BUSY, REG_ADDR, REG_DATA_WRITE, REG_WRITE_REQ, REG_READ_REQ}
  function automatic logic [28:0] pk(logic [1:0] done, logic [1:0] err, logic [7:0] rdata,
                                     logic busy, logic [5:0] ra, logic [7:0] rw,
                                     logic wr, logic rr);
    return {done, err, rdata, busy, ra, rw, wr, rr};
  endfunction

  function automatic logic [28:0] e_idle(logic [5:0] ra, logic [7:0] rw);
    return pk(2'b00, 2'b00, 8'h00, 1'b0, ra, rw, 1'b0, 1'b0);
  endfunction

  function automatic logic [28:0] e_wr(logic [5:0] ra, logic [7:0] rw);
    return pk(2'b00, 2'b00, 8'h00, 1'b1, ra, rw, 1'b1, 1'b0);
  endfunction

  function automatic logic [28:0] e_rd(logic [5:0] ra, logic [7:0] rw);
    return pk(2'b00, 2'b00, 8'h00, 1'b1, ra, rw, 1'b0, 1'b1);
  endfunction

  function automatic logic [28:0] e_fin(logic [1:0] done, logic [1:0] err, logic [7:0] rdata,
                                        logic [5:0] ra, logic [7:0] rw);
    return pk(done, err, rdata, 1'b1, ra, rw, 1'b0, 1'b0);
  endfunction

  function automatic void add(logic [1:0] req, logic [1:0] we, logic [11:0] addr,
                              logic [15:0] wdata, logic [7:0] rd, logic wack, logic rack,
                              logic [28:0] exp);
    vec_t v;
    v.rst   = 1'b0;
    v.req   = req;
    v.we    = we;
    v.addr  = addr;
    v.wdata = wdata;
    v.rd    = rd;
    v.wack  = wack;
    v.rack  = rack;
    v.exp   = exp;
    vecs.push_back(v);
  endfunction

  function automatic logic [28:0] outs();
    return {DONE, ERR, RDATA, BUSY, REG_ADDR, REG_DATA_WRITE, REG_WRITE_REQ, REG_READ_REQ};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    RST           = v.rst;
    REQ           = v.req;
    WE            = v.we;
    ADDR          = v.addr;
    WDATA         = v.wdata;
    REG_DATA_READ = v.rd;
    REG_WRITE_ACK = v.wack;
    REG_READ_ACK  = v.rack;
  endtask

  task automatic idle_inputs();
    REQ = 2'b00; WE = 2'b00; ADDR = '0; WDATA = '0;
    REG_DATA_READ = 8'h00; REG_WRITE_ACK = 1'b0; REG_READ_ACK = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Contention: R0 writes 0x04<-0x41, R1 writes 0x07<-0x99, both held high
    add(2'b11, 2'b11, 12'h1C4, 16'h9941, 8'h00, 1'b0, 1'b0, pk(2'b00, 2'b00, 8'h00, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0));
    add(2'b11, 2'b11, 12'h1C4, 16'h9941, 8'h00, 1'b1, 1'b0, e_wr(6'h04, 8'h41));
    add(2'b11, 2'b11, 12'h1C4, 16'h9941, 8'h00, 1'b0, 1'b0, e_fin(2'b01, 2'b00, 8'h00, 6'h04, 8'h41));
    add(2'b11, 2'b11, 12'h1C4, 16'h9941, 8'h00, 1'b0, 1'b0, e_idle(6'h04, 8'h41));
    add(2'b11, 2'b11, 12'h1C4, 16'h9941, 8'h00, 1'b1, 1'b0, e_wr(6'h07, 8'h99));
    add(2'b11, 2'b11, 12'h1C4, 16'h9941, 8'h00, 1'b0, 1'b0, e_fin(2'b10, 2'b00, 8'h00, 6'h07, 8'h99));
    add(2'b11, 2'b11, 12'h1C4, 16'h9941, 8'h00, 1'b0, 1'b0, e_idle(6'h07, 8'h99));
    add(2'b11, 2'b11, 12'h1C4, 16'h9941, 8'h00, 1'b1, 1'b0, e_wr(6'h04, 8'h41));
    add(2'b11, 2'b11, 12'h1C4, 16'h9941, 8'h00, 1'b0, 1'b0, e_fin(2'b01, 2'b00, 8'h00, 6'h04, 8'h41));
    add(2'b11, 2'b11, 12'h1C4, 16'h9941, 8'h00, 1'b0, 1'b0, e_idle(6'h04, 8'h41));
    add(2'b00, 2'b11, 12'h1C4, 16'h9941, 8'h00, 1'b1, 1'b0, e_wr(6'h07, 8'h99));
    add(2'b00, 2'b11, 12'h1C4, 16'h9941, 8'h00, 1'b0, 1'b0, e_fin(2'b10, 2'b00, 8'h00, 6'h07, 8'h99));
    // Stray write ack in IDLE, then R0 write 0x15<-0xA7 with a stray read ack
    add(2'b00, 2'b00, 12'h000, 16'h0000, 8'h00, 1'b1, 1'b0, e_idle(6'h07, 8'h99));
    add(2'b01, 2'b01, 12'h015, 16'h00A7, 8'h00, 1'b0, 1'b0, e_idle(6'h07, 8'h99));
    add(2'b00, 2'b01, 12'h015, 16'h00A7, 8'h33, 1'b0, 1'b1, e_wr(6'h15, 8'hA7));
    add(2'b00, 2'b01, 12'h015, 16'h00A7, 8'h00, 1'b0, 1'b0, e_wr(6'h15, 8'hA7));
    add(2'b00, 2'b01, 12'h015, 16'h00A7, 8'h00, 1'b1, 1'b0, e_wr(6'h15, 8'hA7));
    add(2'b00, 2'b00, 12'h000, 16'h0000, 8'h00, 1'b0, 1'b0, e_fin(2'b01, 2'b00, 8'h00, 6'h15, 8'hA7));
    // Single read: R0 reads 0x0A, ack two cycles after req rises, data 0x5C
    add(2'b01, 2'b00, 12'h00A, 16'h0000, 8'h00, 1'b0, 1'b0, e_idle(6'h15, 8'hA7));
    add(2'b00, 2'b00, 12'h00A, 16'h0000, 8'h00, 1'b0, 1'b0, e_rd(6'h0A, 8'h00));
    add(2'b00, 2'b00, 12'h00A, 16'h0000, 8'h00, 1'b0, 1'b0, e_rd(6'h0A, 8'h00));
    add(2'b00, 2'b00, 12'h00A, 16'h0000, 8'h5C, 1'b0, 1'b1, e_rd(6'h0A, 8'h00));
    add(2'b00, 2'b00, 12'h00A, 16'h0000, 8'h00, 1'b0, 1'b0, e_fin(2'b01, 2'b00, 8'h5C, 6'h0A, 8'h00));
    // Timeout: R1 write 0x2B<-0x5E never acked; R0 read of 0x11 waits and wins next
    add(2'b10, 2'b10, 12'hAD1, 16'h5E00, 8'h00, 1'b0, 1'b0, e_idle(6'h0A, 8'h00));
    for (int k = 0; k < int'(TO); k++)
      add(2'b11, 2'b10, 12'hAD1, 16'h5E00, 8'h00, 1'b0, 1'b0, e_wr(6'h2B, 8'h5E));
    add(2'b11, 2'b10, 12'hAD1, 16'h5E00, 8'h00, 1'b0, 1'b0, e_fin(2'b10, 2'b10, 8'h00, 6'h2B, 8'h5E));
    add(2'b11, 2'b10, 12'hAD1, 16'h5E00, 8'h00, 1'b0, 1'b0, e_idle(6'h2B, 8'h5E));
    add(2'b00, 2'b10, 12'hAD1, 16'h5E00, 8'hC3, 1'b0, 1'b1, e_rd(6'h11, 8'h00));
    add(2'b00, 2'b00, 12'h000, 16'h0000, 8'h00, 1'b0, 1'b0, e_fin(2'b01, 2'b00, 8'hC3, 6'h11, 8'h00));
    add(2'b00, 2'b00, 12'h000, 16'h0000, 8'h00, 1'b0, 1'b0, e_idle(6'h11, 8'h00));

    RST = 1'b1;
    idle_inputs();
    repeat (2) @(negedge CLK);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      chk($sformatf("row%0d", i), 32'(outs()), 32'(vecs[i].exp));
      apply(vecs[i]);
    end

    // Reset during ISSUE: R0 read of 0x22 aborted, no DONE, pointer back to 1
    @(negedge CLK);
    REQ = 2'b01; WE = 2'b00; ADDR = 12'h022; WDATA = 16'h0000;
    @(negedge CLK);
    chk("rst_pre_rreq", 32'({REG_READ_REQ, REG_ADDR}), 32'({1'b1, 6'h22}));
    REQ = 2'b00;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_all_zero", 32'(outs()), 32'h0);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_stays_idle", 32'(outs()), 32'h0);
    REQ = 2'b11; WE = 2'b11; ADDR = {6'h21, 6'h03}; WDATA = {8'h66, 8'h12};
    @(negedge CLK);
    chk("post_rst_r0_wins", 32'({BUSY, REG_WRITE_REQ, REG_ADDR, REG_DATA_WRITE}),
        32'({1'b1, 1'b1, 6'h03, 8'h12}));
    REQ = 2'b00; REG_WRITE_ACK = 1'b1;
    @(negedge CLK);
    chk("post_rst_done", 32'({DONE, ERR, REG_WRITE_REQ}), 32'({2'b01, 2'b00, 1'b0}));
    REG_WRITE_ACK = 1'b0;
    @(negedge CLK);
    chk("post_rst_idle", 32'(BUSY), 32'h0);

    // Ack on the timeout cycle, with R1 dropping REQ during ISSUE
    REQ = 2'b10; WE = 2'b00; ADDR = {6'h3F, 6'h00}; WDATA = 16'h0000;
    @(negedge CLK);
    chk("to_ack_rreq", 32'({REG_READ_REQ, REG_ADDR}), 32'({1'b1, 6'h3F}));
    REQ = 2'b00;
    repeat (int'(TO) - 1) @(negedge CLK);
    chk("to_ack_last_cycle", 32'({BUSY, REG_READ_REQ, DONE}), 32'({1'b1, 1'b1, 2'b00}));
    REG_READ_ACK = 1'b1; REG_DATA_READ = 8'h9E;
    @(negedge CLK);
    chk("to_ack_done", 32'({DONE, ERR, RDATA}), 32'({2'b10, 2'b00, 8'h9E}));
    REG_READ_ACK = 1'b0; REG_DATA_READ = 8'h00;
    @(negedge CLK);
    chk("to_ack_idle", 32'({BUSY, DONE}), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ulpi_reg_arb.md
# ulpi_reg_arb

Arbiter and sequencer for the single ULPI PHY register-access port (address, write data, read data, and write/read req/ack). It lets two independent requesters share that port: requester 0 is the PHY configuration sequencer, requester 1 is the host command path. The block serialises their transactions, drives the four-phase req/ack handshake toward the ULPI core, and returns read data or a timeout error to the winning requester. It sits in the `CLK` domain, between the requesters and the ULPI register interface.

## Interface

Parameters:
- `TIMEOUT`, default 1023: cycles to wait for an ack before aborting. The legal range is 1..65535.

Ports:
- `CLK`  in  1  system clock; all logic is in this single domain.
- `RST`  in  1  synchronous, active-high reset.
- `REQ`  in  2  per-requester transaction request, level-sensitive; bit n belongs to requester n.
- `WE`  in  2  per-requester direction; 1 = write, 0 = read.
- `ADDR`  in  12  per-requester register address; requester n uses bits [6n+5:6n].
- `WDATA`  in  16  per-requester write data; requester n uses bits [8n+7:8n].
- `DONE`  out  2  one-cycle completion pulse per requester.
- `ERR`  out  2  per-requester timeout flag; valid only while that requester's `DONE` is high.
- `RDATA`  out  8  read data; valid only while a `DONE` bit is high.
- `BUSY`  out  1  high whenever the state is not IDLE.
- `REG_ADDR`  out  6  address toward the ULPI core.
- `REG_DATA_WRITE`  out  8  write data toward the ULPI core.
- `REG_DATA_READ`  in  8  read data from the ULPI core.
- `REG_WRITE_REQ`  out  1  write request toward the ULPI core.
- `REG_WRITE_ACK`  in  1  write acknowledge from the ULPI core.
- `REG_READ_REQ`  out  1  read request toward the ULPI core.
- `REG_READ_ACK`  in  1  read acknowledge from the ULPI core.

## Operation

State machine with states IDLE, ISSUE and FINISH:
- **IDLE:**
  - If `REQ` is nonzero, pick a winner and go to ISSUE.
  - On entry to ISSUE, register the winner's `ADDR`, `WDATA` and `WE` slices.
- **ISSUE:**
  - Exactly one of `REG_WRITE_REQ` / `REG_READ_REQ` is high, selected by the latched `WE`.
  - `REG_ADDR` and `REG_DATA_WRITE` are held stable for the whole of ISSUE.
  - On the matching ack: capture `REG_DATA_READ` (reads only) and go to FINISH.
  - On timeout: go to FINISH with the error flag set.
- **FINISH:** lasts exactly one cycle, then go to IDLE.
  - The request line is low.
  - `DONE[winner]` = 1.
  - `ERR[winner]` = 1 if the transaction timed out, else 0.
  - `RDATA` = the captured data on a read; 0 on a write or on a timeout.

Arbitration (round-robin, 1-bit last-grant pointer):
- If both requests are high, grant the requester that is not the last winner.
- If only one request is high, grant it.
- The pointer updates on every grant.
- After reset the pointer is 1, so requester 0 wins the first contention.

Timeout:
- A 16-bit counter clears on entry to ISSUE and increments every ISSUE cycle without an ack.
- When the counter equals `TIMEOUT - 1` with no ack, the transaction aborts.

Boundary rules:
- **Ack sources:** only the ack matching the current direction counts. The wrong-direction ack is ignored in ISSUE. Any ack is ignored in IDLE and FINISH.
- **Ack and timeout together:** an ack in the same cycle as the timeout condition wins, so `ERR` = 0.
- **Requester drops `REQ` mid-transaction:** the transaction still completes and the requester still gets `DONE`.
- **Requester holds `REQ` after `DONE`:** it is a new request and competes again in the next IDLE cycle.
- **Minimum spacing:** back-to-back transactions always pass through at least one IDLE cycle.
- **Reset mid-transaction:** on the next edge, state goes to IDLE and all outputs go to 0; the pointer goes to 1. No `DONE` is issued for the aborted transaction.

Reset values: `DONE`, `ERR`, `RDATA`, `BUSY`, `REG_ADDR`, `REG_DATA_WRITE`, `REG_WRITE_REQ` and `REG_READ_REQ` are all 0.

## Timing

- All outputs are registered.
- Cycle numbering, for a grant in cycle t (IDLE, `REQ` sampled):
  - t+1: the request line rises, along with `BUSY`.
  - Ack sampled in cycle a ≥ t+1: the request line is low at a+1, and `DONE` pulses at a+1.
  - a+2: back in IDLE with `BUSY` low.
- Latency with an immediate ack (ack at t+1): `DONE` at t+2, giving a 3-cycle minimum period per transaction.
- Timeout with no ack: the request line is high for exactly `TIMEOUT` cycles, then `DONE` + `ERR` pulse in the following cycle.
- `RDATA` is captured on the ack edge, so the ULPI core may change `REG_DATA_READ` after its ack.

## Test plan

- **Single read:** R0 reads address 0x0A; the model acks 2 cycles after req with data 0x5C. Required: `REG_READ_REQ` high for exactly 3 cycles, `REG_ADDR` = 0x0A, `DONE[0]` pulses one cycle after the ack with `RDATA` = 0x5C and `ERR` = 0.
- **Contention:** R0 writes 0x04 ← 0x41 and R1 writes 0x07 ← 0x99, both requesting in the same cycle, and both keep `REQ` high afterwards. Required grant order is R0, R1, R0, R1, with each `REG_DATA_WRITE` matching its owner.
- **Timeout:** `TIMEOUT` = 8 with no ack. Required: `REG_WRITE_REQ` high for 8 cycles, then `DONE[1]` = 1 and `ERR[1]` = 1, and R0 is granted next if it is requesting.
- **Stray acks:** `REG_READ_ACK` pulses during a write, and `REG_WRITE_ACK` pulses in IDLE. Required: both are ignored and the write completes only on `REG_WRITE_ACK`.
- **Reset mid-transaction:** assert `RST` for 1 cycle during ISSUE. Required: the next cycle has all outputs 0 with no `DONE`, and a fresh R0 request afterwards completes normally.
- **Ack with timeout and mid-transaction drop:** an ack arrives on the timeout cycle, and the requester drops `REQ` during ISSUE. Required: `DONE` with `ERR` = 0 and valid `RDATA`.
